// File: rtl/sidecar_pkg.sv
// Shared types and default constants for the side-road vehicle detector.
package sidecar_pkg;

    // Controller-facing service state of the side road
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

    localparam int DEB_CYCLES_DEF    = 4;
    localparam int QW_DEF            = 4;
    localparam int STARVE_CYCLES_DEF = 200;

    // Saturating increment toward an upper bound, used by the wait counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic [15:0] lim);
        logic [15:0] res;
        if (val >= lim) begin
            res = lim;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sidecar_detector_sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-stable-cycle debounce filter.
// rise_pulse is a one-cycle pulse issued the cycle after the filtered level rises.
module sync_debounce
    import sidecar_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state logic: synchronizer shift, stability count, level flip and rise detect
    always_comb begin
        sync1_d     = din;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        rise_d      = level_q & ~level_dly_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers, asynchronously cleared so a partial debounce is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/sidecar_detector.sv
// Side-road vehicle detector: debounced loop sensor, vehicle queue counter,
// IDLE/WAIT/SERVE tracker and registered service request.
// Optional starvation monitor enabled by defining SIDECAR_STARVE_EN.
module sidecar_detector
    import sidecar_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int QW            = QW_DEF,
    parameter int STARVE_CYCLES = STARVE_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          loop_raw,
    input  logic          sg,
    output logic          sidecar,
    output logic [QW-1:0] queue,
    output logic          overflow,
    output logic          starve
);

    localparam logic [QW-1:0] Q_MAX = {QW{1'b1}};

    logic          filt_level_s;
    logic          rise_s;
    logic          veh_pulse_s;
    logic [QW-1:0] queue_q, queue_d;
    logic          overflow_q, overflow_d;
    logic          sidecar_q, sidecar_d;
    state_e        state_q, state_d;

    sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sync_debounce (
        .clk        (clk),
        .rst        (rst),
        .din        (loop_raw),
        .level      (filt_level_s),
        .rise_pulse (rise_s)
    );

    // The pulse always falls inside the filtered-high window; gating keeps the two consistent
    assign veh_pulse_s = rise_s & filt_level_s;

    // Queue update: arrivals with sg low, departures with sg high, both saturating
    always_comb begin
        queue_d    = queue_q;
        overflow_d = overflow_q;
        if (veh_pulse_s) begin
            if (sg) begin
                if (queue_q != '0) begin
                    queue_d = queue_q - QW'(1);
                end else begin
                    queue_d = queue_q;
                end
            end else begin
                if (queue_q == Q_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    queue_d = queue_q + QW'(1);
                end
            end
        end else begin
            queue_d = queue_q;
        end
        sidecar_d = (queue_q != '0);
    end

    // FSM next state from the current green indication and queue occupancy
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sg) begin
                    state_d = ST_SERVE;
                end else if (queue_q != '0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sg) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SERVE: begin
                if (sg) begin
                    state_d = ST_SERVE;
                end else if (queue_q != '0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue, overflow, request and FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            queue_q    <= '0;
            overflow_q <= 1'b0;
            sidecar_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            queue_q    <= queue_d;
            overflow_q <= overflow_d;
            sidecar_q  <= sidecar_d;
            state_q    <= state_d;
        end
    end

    assign queue    = queue_q;
    assign overflow = overflow_q;
    assign sidecar  = sidecar_q;

`ifdef SIDECAR_STARVE_EN
    localparam int WCW = $clog2(STARVE_CYCLES + 1);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           starve_q, starve_d;
    logic [15:0]    wait_inc_s;

    // Count clocks spent in WAIT (using the next state so leaving clears at once)
    always_comb begin
        wait_inc_s = sat_inc16(16'(wait_cnt_q), 16'(STARVE_CYCLES));
        if (state_d == ST_WAIT) begin
            wait_cnt_d = wait_inc_s[WCW-1:0];
        end else begin
            wait_cnt_d = '0;
        end
        starve_d = (wait_cnt_d >= WCW'(STARVE_CYCLES));
    end

    // Wait counter and starvation flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            starve_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_sidecar_detector.sv
// Directed self-checking bench for sidecar_detector (DEB_CYCLES=4).
// dut_a uses QW=4, dut_b uses QW=2 for saturation; both share all inputs.
module tb_sidecar_detector;
    import sidecar_pkg::*;

    localparam int DEB = 4;
`ifdef SIDECAR_STARVE_EN
    localparam logic STARVE_EXP = 1'b1;
`else
    localparam logic STARVE_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       loop_raw;
    logic       sg;
    logic       sidecar_a, overflow_a, starve_a;
    logic [3:0] queue_a;
    logic       sidecar_b, overflow_b, starve_b;
    logic [1:0] queue_b;
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sidecar_detector #(.DEB_CYCLES(DEB), .QW(4), .STARVE_CYCLES(10)) dut_a (
        .clk(clk), .rst(rst), .loop_raw(loop_raw), .sg(sg),
        .sidecar(sidecar_a), .queue(queue_a), .overflow(overflow_a), .starve(starve_a)
    );

    sidecar_detector #(.DEB_CYCLES(DEB), .QW(2), .STARVE_CYCLES(10)) dut_b (
        .clk(clk), .rst(rst), .loop_raw(loop_raw), .sg(sg),
        .sidecar(sidecar_b), .queue(queue_b), .overflow(overflow_b), .starve(starve_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One complete debounced vehicle passage (rise and fall both qualify)
    task automatic vehicle();
        loop_raw = 1'b1;
        step(DEB + 5);
        loop_raw = 1'b0;
        step(DEB + 5);
    endtask

    initial begin
        rst      = 1'b1;
        loop_raw = 1'b0;
        sg       = 1'b0;
        step(2);
        check("rst_sidecar", sidecar_a, 0);
        check("rst_queue", queue_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_starve", starve_a, 0);
        check("rst_state", dut_a.state_q, ST_IDLE);
        rst = 1'b0;
        step(1);

        // Clean rise: sampled at edge N, queue moves at N+7, sidecar at N+8
        loop_raw = 1'b1;
        step(7);
        check("lat_q_n6", queue_a, 0);
        step(1);
        check("lat_q_n7", queue_a, 1);
        check("lat_sc_n7", sidecar_a, 0);
        check("lat_st_n7", dut_a.state_q, ST_IDLE);
        step(1);
        check("lat_sc_n8", sidecar_a, 1);
        check("lat_st_n8", dut_a.state_q, ST_WAIT);
        loop_raw = 1'b0;
        step(DEB + 5);

        // Glitch of three clocks must not qualify
        loop_raw = 1'b1;
        step(3);
        loop_raw = 1'b0;
        step(15);
        check("glitch_q_a", queue_a, 1);
        check("glitch_q_b", queue_b, 1);

        // Two more arrivals
        vehicle();
        vehicle();
        check("arr3_q_a", queue_a, 3);
        check("arr3_q_b", queue_b, 3);
        check("arr3_ovf_b", overflow_b, 0);
        check("arr3_state", dut_a.state_q, ST_WAIT);

        // Green: serve, two departures
        sg = 1'b1;
        step(1);
        check("serve_state", dut_a.state_q, ST_SERVE);
        vehicle();
        vehicle();
        check("dep2_q_a", queue_a, 1);
        check("dep2_state", dut_a.state_q, ST_SERVE);
        sg = 1'b0;
        step(1);
        check("rewait_state", dut_a.state_q, ST_WAIT);
        check("rewait_starve", starve_a, 0);
        step(1);
        check("rewait_sc", sidecar_a, 1);

        // Saturation in the QW=2 instance
        vehicle();
        check("ovf_q2_b", queue_b, 2);
        check("ovf_f2_b", overflow_b, 0);
        vehicle();
        check("ovf_q3_b", queue_b, 3);
        check("ovf_f3_b", overflow_b, 0);
        vehicle();
        check("ovf_hold_b", queue_b, 3);
        check("ovf_set_b", overflow_b, 1);
        check("ovf_q_a", queue_a, 4);
        check("ovf_none_a", overflow_a, 0);
        vehicle();
        check("ovf_sticky_b", overflow_b, 1);
        check("ovf_q5_a", queue_a, 5);

        // Long WAIT: starvation flag only when the monitor is built in
        check("starve_wait", starve_a, 32'(STARVE_EXP));
        sg = 1'b1;
        step(1);
        check("starve_clear", starve_a, 0);
        check("starve_serve", dut_a.state_q, ST_SERVE);
        sg = 1'b0;
        step(1);

        // Reset mid-debounce with a populated queue
        loop_raw = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        check("mrst_q_a", queue_a, 0);
        check("mrst_sc_a", sidecar_a, 0);
        check("mrst_ovf_b", overflow_b, 0);
        check("mrst_starve", starve_a, 0);
        check("mrst_state", dut_a.state_q, ST_IDLE);
        step(1);
        rst = 1'b0;
        step(7);
        check("post_rst_n6", queue_a, 0);
        step(1);
        check("post_rst_n7", queue_a, 1);
        loop_raw = 1'b0;
        step(DEB + 5);

        // Departures at an empty queue hold at zero without flag
        sg = 1'b1;
        vehicle();
        check("empty_q1", queue_a, 0);
        vehicle();
        check("empty_q2", queue_a, 0);
        check("empty_ovf", overflow_a, 0);
        sg = 1'b0;
        step(2);
        check("empty_state", dut_a.state_q, ST_IDLE);
        check("empty_sc", sidecar_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
